// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared FSM state type and access-type constants for the data memory responder
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    // Latency counter width; covers LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/data_mem_responder_mem_bank.sv
// rtl/data_mem_responder_mem_bank.sv - word array with byte-enable synchronous write and registered read
module mem_bank #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    localparam int AW         = $clog2(DEPTH),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  clr_i,
    input  logic [NB-1:0]         be_i,
    input  logic [AW-1:0]         idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane write; the array has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register: full word on a read, zero on any other completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency single-outstanding data memory responder
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_re,
    input  logic [3:0]            mask,
    input  logic [ADDRESS-1:0]    address,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic                  busy,
    output logic                  error
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;
    // With LATENCY=1 the access happens on the accept edge itself, using live inputs.
    localparam bit DIRECT = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [3:0]            mask_q;
    logic [ADDRESS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  valid_q, error_q;

    logic                  accept, do_access, in_range, wr_en, rd_en;
    logic                  acc_we;
    logic [3:0]            acc_mask;
    logic [ADDRESS-1:0]    acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  unused_addr_lsbs;

    // A new access may start only when nothing is pending or on the response cycle.
    assign accept = request && (state_q == IDLE || state_q == RESP);

    // The counter reaches zero on the edge that performs the access.
    assign do_access = (accept && DIRECT) || (state_q == WAIT && cnt_q == CNT_ONE);

    assign acc_we    = DIRECT ? we_re      : we_q;
    assign acc_mask  = DIRECT ? mask       : mask_q;
    assign acc_addr  = DIRECT ? address    : addr_q;
    assign acc_wdata = DIRECT ? store_data : wdata_q;

    assign in_range = ((acc_addr >> (AW + 2)) == '0);
    // Sub-word address bits are deliberately ignored (no misalignment trap).
    assign unused_addr_lsbs = ^acc_addr[1:0];

    // Reset low on the access edge drops the pending write.
    assign wr_en = rst && do_access && in_range && (acc_we == WE_WRITE);
    assign rd_en = rst && do_access && in_range && (acc_we == WE_READ);

    // Next-state and latency counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    cnt_d   = CNT_LOAD;
                    state_d = DIRECT ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and the request fields captured on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_re;
                mask_q  <= mask;
                addr_q  <= address;
                wdata_q <= store_data;
            end
        end
    end

    // Registered completion pulse and its out-of-range qualifier.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= do_access;
            error_q <= do_access && !in_range;
        end
    end

    mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (wr_en),
        .rd_en_i (rd_en),
        .clr_i   (do_access),
        .be_i    (NB'(acc_mask)),
        .idx_i   (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (load_data)
    );

    assign valid = valid_q;
    assign error = error_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have parameter ADDRESS, default 32, byte-address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024, number of storage words (power of two).
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request acceptance to valid; legal range 1..15.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port request, input, 1, initiator access strobe.
REQ-008 SHALL have port we_re, input, 1, access type: 1 = write (store), 0 = read (load).
REQ-009 SHALL have port mask, input, 4, byte-lane enables; bit i covers bits [8i+7:8i].
REQ-010 SHALL have port address, input, ADDRESS, byte address.
REQ-011 SHALL have port store_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port load_data, output, DATA_WIDTH, read data; meaningful only while valid=1.
REQ-013 SHALL have port valid, output, 1, one-cycle completion pulse for the accepted access.
REQ-014 SHALL have port busy, output, 1, high while an accepted access is outstanding.
REQ-015 SHALL have port error, output, 1, qualifies valid; out-of-range access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: request=1 -> capture address, we_re, mask, store_data; load counter with LATENCY-1; go WAIT, or RESP directly when LATENCY=1.
REQ-018 WAIT: decrement counter each cycle; at 0 perform the access and go RESP.
REQ-019 RESP: valid=1 for exactly one cycle; request=1 in this cycle is accepted as in IDLE (back-to-back); otherwise go IDLE.
REQ-020 Request in WAIT SHALL be ignored; no queuing. Initiator holds request until valid.
REQ-021 Latency request-accept edge to valid SHALL be exactly LATENCY cycles; back-to-back throughput one access per LATENCY cycles.
REQ-022 Word index = address[log2(DEPTH)+1:2]; address[1:0] ignored (no misalignment trap).
REQ-023 Write: update only lanes with mask bit set; mask=4'b0000 writes nothing but still completes with valid.
REQ-024 Read: load_data = full stored word regardless of mask; initiator performs lane extraction/sign extension.
REQ-025 address >= DEPTH*4: no write, load_data=0, error=1 together with valid.
REQ-026 busy=1 in WAIT and RESP, 0 in IDLE.
REQ-027 load_data, valid, error SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-028 rst=0 at a clock edge: state IDLE, counter 0, valid=0, error=0, busy=0, load_data=0.
REQ-029 Reset mid-operation SHALL drop the pending access: no write, no valid.
REQ-030 Storage array SHALL NOT be reset; contents survive reset.

Structure
REQ-031 Shared package mem_if_pkg SHALL hold the FSM state enum and WE_WRITE=1 / WE_READ=0 constants, reused by the core side.
REQ-032 One sub-module mem_bank SHALL hold the array: byte-enable synchronous write, synchronous read, DEPTH parameter.

Verification
REQ-033 Write addr 0x10, data 0xDEADBEEF, mask 4'hF, then read 0x10 -> valid 2 cycles after each accept, load_data=0xDEADBEEF, error=0.
REQ-034 Over word 0x11223344 at 0x20 write mask 4'b0010 data 0x0000AA00, read -> 0x1122AA44.
REQ-035 Read 0x1000 (DEPTH=1024) -> valid with error=1, load_data=0; prior write to 0x1000 leaves all words unchanged.
REQ-036 Request held continuously for 4 reads with LATENCY=2 -> valid pulses every 2 cycles, busy never drops between them.
REQ-037 Write 0x55 accepted, rst=0 the next cycle -> no valid; subsequent read of that address returns the old value.
REQ-038 LATENCY=1, read request in IDLE -> valid on the next edge; request toggled during WAIT with LATENCY=3 -> ignored, single valid.
